// File: rtl/sample_page_scheduler.sv
// -----------------------------------------------------------------------------
// sample_page_scheduler
//
// Collects 8-bit ADC samples into a ping-pong pair of page buffers and feeds
// them to the I2C EEPROM leader one page at a time. The block issues the start
// address, supplies data bytes, and waits out the EEPROM write cycle (tWR)
// after every page. NACKed pages are retried and eventually abandoned. It also
// tracks how many pages were committed and flags dropped samples and a full
// memory.
//
// Ports:
//   CLK_50MHz      in   system clock, rising edge
//   RESET          in   asynchronous active-high reset
//   sample_valid   in   one-cycle strobe, sample_word valid
//   sample_word    in   8-bit ADC sample
//   eep_start      out  one-cycle pulse, begin page write at eep_addr
//   eep_addr       out  EEPROM byte address of the page being written
//   eep_byte_rd    in   one-cycle strobe, I2C leader takes the next byte
//   eep_byte_data  out  registered data byte, valid the cycle after eep_byte_rd
//   eep_done       in   one-cycle strobe, page transfer finished
//   eep_nack       in   qualified by eep_done, page was NACKed
//   pages_written  out  number of committed pages
//   overflow       out  sticky, a sample was dropped
//   write_error    out  sticky, a page was abandoned after MAX_RETRY retries
//   mem_full       out  the whole EEPROM has been written
// -----------------------------------------------------------------------------
module sample_page_scheduler #(
    parameter int PAGE_BYTES = 64,
    parameter int ADDR_W     = 16,
    parameter int MEM_PAGES  = 512,
    parameter int TWR_CYCLES = 250000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                         CLK_50MHz,
    input  logic                         RESET,
    input  logic                         sample_valid,
    input  logic [7:0]                   sample_word,
    output logic                         eep_start,
    output logic [ADDR_W-1:0]            eep_addr,
    input  logic                         eep_byte_rd,
    output logic [7:0]                   eep_byte_data,
    input  logic                         eep_done,
    input  logic                         eep_nack,
    output logic [$clog2(MEM_PAGES):0]   pages_written,
    output logic                         overflow,
    output logic                         write_error,
    output logic                         mem_full
);

    localparam int IDX_W = $clog2(PAGE_BYTES);
    localparam int PP_W  = $clog2(MEM_PAGES) + 1;
    localparam int RT_W  = $clog2(MAX_RETRY + 1);
    localparam int TW_W  = $clog2(TWR_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_BYTES - 1);

    // Drain FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_XFER     = 3'd2;
    localparam logic [2:0] ST_TWR_WAIT = 3'd3;
    localparam logic [2:0] ST_FULL     = 3'd4;

    // Per-buffer state. The buffer being filled stays EMPTY until its last byte.
    localparam logic [1:0] BUF_EMPTY = 2'd0;
    localparam logic [1:0] BUF_READY = 2'd1;
    localparam logic [1:0] BUF_DRAIN = 2'd2;

    logic [2:0]            state_q, state_d;
    logic [1:0][1:0]       buf_st_q, buf_st_d;
    logic                  fill_sel_q, fill_sel_d;
    logic                  fill_avail_q, fill_avail_d;
    logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
    logic                  ready_first_q, ready_first_d;
    logic                  drain_sel_q, drain_sel_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [RT_W-1:0]       retry_q, retry_d;
    logic [TW_W-1:0]       twr_cnt_q, twr_cnt_d;
    logic [PP_W-1:0]       page_ptr_q, page_ptr_d;
    logic [PP_W-1:0]       pages_written_q, pages_written_d;
    logic                  overflow_q, overflow_d;
    logic                  write_error_q, write_error_d;
    logic [7:0]            eep_byte_data_q, eep_byte_data_d;

    logic                  mem_we;
    logic                  other_sel;
    logic                  page_free;
    logic                  drain_pick;

    logic [7:0]            page_mem [2][PAGE_BYTES];

    assign other_sel = ~fill_sel_q;

    // The draining buffer is released on an ACK or on the final NACK.
    assign page_free = (state_q == ST_XFER) && eep_done &&
                       (!eep_nack || (retry_q == RT_W'(MAX_RETRY)));

    // Oldest READY buffer wins when both are waiting.
    assign drain_pick = ((buf_st_q[0] == BUF_READY) && (buf_st_q[1] == BUF_READY)) ?
                        ready_first_q : (buf_st_q[1] == BUF_READY);

    // NOTE: sample storage has no reset; only the buffer state flags need one,
    // and stale bytes are never read because a page is only drained once full.
    always_ff @(posedge CLK_50MHz) begin
        if (mem_we) begin
            page_mem[fill_sel_q][fill_idx_q] <= sample_word;
        end
    end

    always_comb begin
        // NOTE: every next-state value starts as a hold of the current state so
        // that no branch leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        buf_st_d        = buf_st_q;
        fill_sel_d      = fill_sel_q;
        fill_avail_d    = fill_avail_q;
        fill_idx_d      = fill_idx_q;
        ready_first_d   = ready_first_q;
        drain_sel_d     = drain_sel_q;
        rd_idx_d        = rd_idx_q;
        retry_d         = retry_q;
        twr_cnt_d       = twr_cnt_q;
        page_ptr_d      = page_ptr_q;
        pages_written_d = pages_written_q;
        overflow_d      = overflow_q;
        write_error_d   = write_error_q;
        eep_byte_data_d = eep_byte_data_q;
        mem_we          = 1'b0;

        // ---------------- fill side ----------------
        if (sample_valid && (state_q != ST_FULL)) begin
            if (fill_avail_q) begin
                mem_we     = 1'b1;
                // PAGE_BYTES is a power of two, so the index wraps to 0 by itself.
                fill_idx_d = fill_idx_q + 1'b1;
                if (fill_idx_q == LAST_IDX) begin
                    buf_st_d[fill_sel_q] = BUF_READY;
                    if (buf_st_q[other_sel] != BUF_READY) begin
                        ready_first_d = fill_sel_q;
                    end
                    // A buffer released this very cycle is as good as EMPTY.
                    if ((buf_st_q[other_sel] == BUF_EMPTY) ||
                        (page_free && (drain_sel_q == other_sel))) begin
                        fill_sel_d = other_sel;
                    end else begin
                        fill_avail_d = 1'b0;
                    end
                end
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Stalled filling restarts at index 0 of the buffer just released.
        if (!fill_avail_q && page_free) begin
            fill_sel_d   = drain_sel_q;
            fill_avail_d = 1'b1;
            fill_idx_d   = '0;
        end

        // ---------------- drain FSM ----------------
        case (state_q)
            ST_IDLE: begin
                if ((buf_st_q[0] == BUF_READY) || (buf_st_q[1] == BUF_READY)) begin
                    drain_sel_d          = drain_pick;
                    buf_st_d[drain_pick] = BUF_DRAIN;
                    rd_idx_d             = '0;
                    retry_d              = '0;
                    state_d              = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (eep_byte_rd) begin
                    eep_byte_data_d = page_mem[drain_sel_q][rd_idx_q];
                    rd_idx_d        = rd_idx_q + 1'b1;
                end
                if (eep_done) begin
                    twr_cnt_d = TW_W'(TWR_CYCLES - 1);
                    state_d   = ST_TWR_WAIT;
                    if (!eep_nack) begin
                        buf_st_d[drain_sel_q] = BUF_EMPTY;
                        page_ptr_d            = page_ptr_q + 1'b1;
                        pages_written_d       = pages_written_q + 1'b1;
                    end else if (retry_q < RT_W'(MAX_RETRY)) begin
                        retry_d  = retry_q + 1'b1;
                        rd_idx_d = '0;
                    end else begin
                        // Give up on this page and move past the bad location.
                        write_error_d         = 1'b1;
                        buf_st_d[drain_sel_q] = BUF_EMPTY;
                        page_ptr_d            = page_ptr_q + 1'b1;
                    end
                end
            end
            ST_TWR_WAIT: begin
                if (twr_cnt_q == '0) begin
                    // The drained buffer is still in DRAIN only while retrying.
                    if (buf_st_q[drain_sel_q] == BUF_DRAIN) begin
                        state_d = ST_START;
                    end else if (page_ptr_q == PP_W'(MEM_PAGES)) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    twr_cnt_d = twr_cnt_q - 1'b1;
                end
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed for this cycle, independent of statement order.
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            buf_st_q        <= {BUF_EMPTY, BUF_EMPTY};
            fill_sel_q      <= 1'b0;
            fill_avail_q    <= 1'b1;
            fill_idx_q      <= '0;
            ready_first_q   <= 1'b0;
            drain_sel_q     <= 1'b0;
            rd_idx_q        <= '0;
            retry_q         <= '0;
            twr_cnt_q       <= '0;
            page_ptr_q      <= '0;
            pages_written_q <= '0;
            overflow_q      <= 1'b0;
            write_error_q   <= 1'b0;
            eep_byte_data_q <= '0;
        end else begin
            state_q         <= state_d;
            buf_st_q        <= buf_st_d;
            fill_sel_q      <= fill_sel_d;
            fill_avail_q    <= fill_avail_d;
            fill_idx_q      <= fill_idx_d;
            ready_first_q   <= ready_first_d;
            drain_sel_q     <= drain_sel_d;
            rd_idx_q        <= rd_idx_d;
            retry_q         <= retry_d;
            twr_cnt_q       <= twr_cnt_d;
            page_ptr_q      <= page_ptr_d;
            pages_written_q <= pages_written_d;
            overflow_q      <= overflow_d;
            write_error_q   <= write_error_d;
            eep_byte_data_q <= eep_byte_data_d;
        end
    end

    // page_ptr only changes on eep_done, so the address is stable for a transfer.
    assign eep_addr      = ADDR_W'({page_ptr_q, {IDX_W{1'b0}}});
    assign eep_start     = (state_q == ST_START);
    assign mem_full      = (state_q == ST_FULL);
    assign eep_byte_data = eep_byte_data_q;
    assign pages_written = pages_written_q;
    assign overflow      = overflow_q;
    assign write_error   = write_error_q;

endmodule

// File: tb/tb_sample_page_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sample_page_scheduler
//
// Self-checking bench for sample_page_scheduler. The bench plays the ADC
// leader and the I2C EEPROM leader. Inputs change right after a falling edge
// and outputs are read at the next falling edge.
// -----------------------------------------------------------------------------
module tb_sample_page_scheduler;

    localparam int PB   = 64;
    localparam int AW   = 16;
    localparam int MP   = 8;
    localparam int TW   = 20;
    localparam int MR   = 3;
    localparam int PW_W = $clog2(MP) + 1;

    logic            clk;
    logic            rst;
    logic            sample_valid;
    logic [7:0]      sample_word;
    logic            eep_start;
    logic [AW-1:0]   eep_addr;
    logic            eep_byte_rd;
    logic [7:0]      eep_byte_data;
    logic            eep_done;
    logic            eep_nack;
    logic [PW_W-1:0] pages_written;
    logic            overflow;
    logic            write_error;
    logic            mem_full;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_page [PB];

    typedef struct {
        int            nacks;
        logic [AW-1:0] exp_addr;
        int            exp_pw;
        logic          exp_werr;
    } page_vec_t;

    page_vec_t vecs [5];

    sample_page_scheduler #(
        .PAGE_BYTES (PB),
        .ADDR_W     (AW),
        .MEM_PAGES  (MP),
        .TWR_CYCLES (TW),
        .MAX_RETRY  (MR)
    ) dut (
        .CLK_50MHz     (clk),
        .RESET         (rst),
        .sample_valid  (sample_valid),
        .sample_word   (sample_word),
        .eep_start     (eep_start),
        .eep_addr      (eep_addr),
        .eep_byte_rd   (eep_byte_rd),
        .eep_byte_data (eep_byte_data),
        .eep_done      (eep_done),
        .eep_nack      (eep_nack),
        .pages_written (pages_written),
        .overflow      (overflow),
        .write_error   (write_error),
        .mem_full      (mem_full)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle with the given inputs, ending at the next falling edge.
    task automatic drive(input logic sv, input logic [7:0] sw, input logic rd,
                         input logic dn, input logic nk);
        sample_valid = sv;
        sample_word  = sw;
        eep_byte_rd  = rd;
        eep_done     = dn;
        eep_nack     = nk;
        @(negedge clk);
        sample_valid = 1'b0;
        eep_byte_rd  = 1'b0;
        eep_done     = 1'b0;
        eep_nack     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  32'(eep_start), 0);
        check({tag, "_addr"},   32'(eep_addr), 0);
        check({tag, "_data"},   32'(eep_byte_data), 0);
        check({tag, "_pw"},     32'(pages_written), 0);
        check({tag, "_ovf"},    32'(overflow), 0);
        check({tag, "_werr"},   32'(write_error), 0);
        check({tag, "_full"},   32'(mem_full), 0);
    endtask

    task automatic fill_exp(input logic [7:0] seed);
        for (int i = 0; i < PB; i++) exp_page[i] = seed + 8'(i);
    endtask

    task automatic push_page(input logic [7:0] seed);
        for (int i = 0; i < PB; i++) drive(1'b1, seed + 8'(i), 1'b0, 1'b0, 1'b0);
    endtask

    // Idles until eep_start is seen; n is the number of cycles waited.
    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (!eep_start && n < budget) begin
            idle_cycles(1);
            n++;
        end
        if (!eep_start) check("start_timeout", 32'(eep_start), 1);
    endtask

    task automatic read_page(input int count, input string tag);
        for (int i = 0; i < count; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check(tag, 32'(eep_byte_data), 32'(exp_page[i]));
        end
    endtask

    // Randomized traffic against a page-queue model of the scheduler.
    task automatic run_random();
        logic [7:0] m_bytes [$];
        int   m_pend  = 0;
        int   m_ptr   = 0;
        int   m_pw    = 0;
        int   m_retry = 0;
        logic m_ovf   = 1'b0;
        int   m_werr  = 0;
        int   ls      = 0;
        int   rd_n    = 0;
        int   wait_cnt = 0;
        int   cyc     = 0;
        int   rate    = 50;
        logic abort   = 1'b0;
        logic sv, rd, dn, nk;
        logic [7:0] sw, exp_b;

        do_reset();
        while (!(m_ptr >= 6 && ls == 0) && cyc < 30000 && !abort) begin
            cyc++;
            sv    = ($urandom_range(0, 99) < rate);
            sw    = 8'($urandom);
            rd    = 1'b0;
            dn    = 1'b0;
            nk    = 1'b0;
            exp_b = 8'h00;
            if (ls == 0) begin
                if (eep_start) begin
                    check("rnd_start_pending", 32'(m_pend > 0), 1);
                    check("rnd_addr", 32'(eep_addr), 32'(m_ptr * PB));
                    ls   = 2;
                    rd_n = 0;
                    wait_cnt = 0;
                end else if (m_pend > 0) begin
                    wait_cnt++;
                    if (wait_cnt > 2 * TW + 10) begin
                        check("rnd_start_timeout", 32'(eep_start), 1);
                        abort = 1'b1;
                    end
                end
            end else if (rd_n < PB) begin
                rd = 1'($urandom_range(0, 1));
                if (rd) exp_b = m_bytes[rd_n];
            end else begin
                dn = ($urandom_range(0, 2) == 0);
                nk = dn && ($urandom_range(0, 3) == 0);
            end

            // Model: a sample is kept only while fewer than two whole pages
            // are waiting; a released page counts only after this sample.
            if (sv) begin
                if (m_pend < 2) begin
                    m_bytes.push_back(sw);
                    if (m_bytes.size() == (m_pend + 1) * PB) m_pend++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (dn) begin
                if (!nk || m_retry == MR) begin
                    repeat (PB) void'(m_bytes.pop_front());
                    m_pend--;
                    m_ptr++;
                    if (!nk) m_pw++;
                    else     m_werr = 1;
                    m_retry = 0;
                end else begin
                    m_retry++;
                end
            end

            drive(sv, sw, rd, dn, nk);

            if (rd) begin
                check("rnd_byte", 32'(eep_byte_data), 32'(exp_b));
                rd_n++;
            end
            if (dn) begin
                check("rnd_pw", 32'(pages_written), 32'(m_pw));
                check("rnd_werr", 32'(write_error), 32'(m_werr));
                check("rnd_ovf", 32'(overflow), 32'(m_ovf));
                ls = 0;
                wait_cnt = 0;
                rate = $urandom_range(20, 90);
            end
        end
        check("rnd_progress", 32'(m_ptr >= 6), 1);
        check("rnd_final_ovf", 32'(overflow), 32'(m_ovf));
        check("rnd_final_full", 32'(mem_full), 0);
    endtask

    initial begin
        int n;
        int starts;
        logic nk;

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_word  = 8'h00;
        eep_byte_rd  = 1'b0;
        eep_done     = 1'b0;
        eep_nack     = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        check_all_zero("rst");

        // ---------------- first page, latency, tWR hold-off ----------------
        fill_exp(8'h00);
        push_page(8'h00);
        check("lat_ready_cycle", 32'(eep_start), 0);
        idle_cycles(1);
        check("lat_start", 32'(eep_start), 1);
        check("addr_page0", 32'(eep_addr), 32'h0000);
        idle_cycles(1);
        check("start_one_cycle", 32'(eep_start), 0);
        // Next page arrives while this one is read out.
        for (int i = 0; i < PB; i++) begin
            drive(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
            check("p0_byte", 32'(eep_byte_data), 32'(exp_page[i]));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("p0_pw", 32'(pages_written), 1);
        wait_start(TW + 10, n);
        check("twr_holdoff", 32'(n), 32'(TW + 1));
        check("addr_page1", 32'(eep_addr), 32'h0040);
        fill_exp(8'h40);
        idle_cycles(1);
        read_page(PB, "p1_byte");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("p1_pw", 32'(pages_written), 2);

        // ---------------- NACK / retry table ----------------
        vecs[0] = '{0, 16'h0000, 1, 1'b0};
        vecs[1] = '{3, 16'h0040, 2, 1'b0};
        vecs[2] = '{4, 16'h0080, 2, 1'b1};
        vecs[3] = '{1, 16'h00C0, 3, 1'b1};
        vecs[4] = '{0, 16'h0100, 4, 1'b1};
        do_reset();
        for (int v = 0; v < 5; v++) begin
            fill_exp(8'(v * 40 + 3));
            push_page(8'(v * 40 + 3));
            wait_start(TW + 10, n);
            for (int a = 0; a <= MR; a++) begin
                check("tbl_addr", 32'(eep_addr), 32'(vecs[v].exp_addr));
                idle_cycles(1);
                read_page(PB, "tbl_byte");
                nk = (a < vecs[v].nacks);
                drive(1'b0, 8'h00, 1'b0, 1'b1, nk);
                if (!nk || a == MR) break;
                wait_start(TW + 5, n);
                check("tbl_retry_wait", 32'(n), 32'(TW));
            end
            check("tbl_pw", 32'(pages_written), 32'(vecs[v].exp_pw));
            check("tbl_werr", 32'(write_error), 32'(vecs[v].exp_werr));
        end

        // ---------------- reset in the middle of a transfer ----------------
        fill_exp(8'h11);
        push_page(8'h11);
        wait_start(TW + 10, n);
        check("mid_addr", 32'(eep_addr), 32'h0140);
        idle_cycles(1);
        read_page(20, "mid_byte");
        #3 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        fill_exp(8'h99);
        push_page(8'h99);
        wait_start(TW + 10, n);
        check("post_rst_addr", 32'(eep_addr), 32'h0000);
        idle_cycles(1);
        read_page(PB, "post_rst_byte");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("post_rst_pw", 32'(pages_written), 1);

        // ---------------- overflow with stalled I2C leader ----------------
        do_reset();
        fill_exp(8'h00);
        push_page(8'h00);
        wait_start(TW + 10, n);
        idle_cycles(1);
        push_page(8'h40);
        check("ovf_before", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        read_page(PB, "ovf_p0_byte");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_start(TW + 10, n);
        check("ovf_p1_addr", 32'(eep_addr), 32'h0040);
        fill_exp(8'h40);
        idle_cycles(1);
        read_page(PB, "ovf_p1_byte");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        push_page(8'h80);
        fill_exp(8'h80);
        wait_start(TW + 10, n);
        check("ovf_p2_addr", 32'(eep_addr), 32'h0080);
        idle_cycles(1);
        read_page(PB, "ovf_p2_byte");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_pw", 32'(pages_written), 3);

        // ---------------- fill the whole memory ----------------
        do_reset();
        for (int p = 0; p < MP; p++) begin
            fill_exp(8'(p * 7));
            push_page(8'(p * 7));
            wait_start(TW + 10, n);
            check("full_addr", 32'(eep_addr), 32'(p * PB));
            idle_cycles(1);
            read_page(PB, "full_byte");
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check("full_pw", 32'(pages_written), 32'(MP));
        idle_cycles(TW - 1);
        check("full_not_yet", 32'(mem_full), 0);
        idle_cycles(1);
        check("full_set", 32'(mem_full), 1);
        starts = 0;
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (eep_start) starts++;
        end
        check("full_no_start", 32'(starts), 0);
        check("full_no_ovf", 32'(overflow), 0);
        check("full_stays", 32'(mem_full), 1);

        // ---------------- randomized traffic ----------------
        run_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
